// File: rtl/multicycle_control_unit.sv
// Control FSM for the 16-bit multicycle datapath: fetch, decode, execute, memory, write-back.
// Stalls on the memory handshake; an illegal opcode or memory timeout parks it in a sticky FAULT.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] inst,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state_dbg
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LUI  = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_LI   = 4'hF;

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [7:0] TIMEOUT    = 8'(TIMEOUT_CYCLES);

    logic [2:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic [3:0] opcode;
    logic       opcode_legal;
    logic       timed_out;
    logic       unused_inst_bits;

    assign opcode           = inst[3:0];
    assign unused_inst_bits = ^inst[15:4];
    assign timed_out        = (wait_q == TIMEOUT) && !mem_ready;

    always_comb begin
        case (opcode)
            OP_R, OP_LUI, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_LI: opcode_legal = 1'b1;
            default:                                           opcode_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wait_q       <= 8'd0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        wait_d       = 8'd0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (opcode_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_ADDI, OP_LUI, OP_LI: state_d = S_WB;
                    OP_LW, OP_SW:                 state_d = S_MEM;
                    OP_BEQ:                       state_d = S_FETCH;
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (timed_out) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        // Counter only survives while waiting in place; any entry or exit clears it.
        if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q) begin
            wait_d = (wait_q == TIMEOUT) ? wait_q : wait_q + 8'd1;
        end
    end

    // Output decode
    always_comb begin
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'd2;
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                    end
                    OP_LUI, OP_LI: begin
                        alu_src_b = 2'd2;
                        alu_op    = 2'b11;
                    end
                    OP_BEQ: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        pc_src    = 1'b1;
                        pc_write  = alu_zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LW);
            end
            default: ;
        endcase
    end

    assign fault      = (state_q == S_FAULT);
    assign fault_code = fault_code_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class cycle by cycle
// against hand-written state and output tables.
module tb_multicycle_control_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] inst;
    logic        mem_ready;
    logic        alu_zero;
    logic        pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        reg_write, wb_sel, fault;
    logic [1:0]  fault_code;
    logic [2:0]  state_dbg;
    logic [15:0] all_out;

    int n_cmp = 0;
    int n_err = 0;

    // Bit order: pc_write pc_src ir_write iord mem_read mem_write a bb oo reg_write wb_sel fault cc
    localparam logic [15:0] O_ZERO    = 16'b0_0_0_0_0_0_0_00_00_0_0_0_00;
    localparam logic [15:0] O_FETCH_R = 16'b1_0_1_0_1_0_0_01_00_0_0_0_00;
    localparam logic [15:0] O_FETCH_W = 16'b0_0_0_0_1_0_0_01_00_0_0_0_00;
    localparam logic [15:0] O_DECODE  = 16'b0_0_0_0_0_0_0_10_00_0_0_0_00;
    localparam logic [15:0] O_EXEC_R  = 16'b0_0_0_0_0_0_1_00_10_0_0_0_00;
    localparam logic [15:0] O_EXEC_I  = 16'b0_0_0_0_0_0_1_10_00_0_0_0_00;
    localparam logic [15:0] O_EXEC_U  = 16'b0_0_0_0_0_0_0_10_11_0_0_0_00;
    localparam logic [15:0] O_MEM_LW  = 16'b0_0_0_1_1_0_0_00_00_0_0_0_00;
    localparam logic [15:0] O_MEM_SW  = 16'b0_0_0_1_0_1_0_00_00_0_0_0_00;
    localparam logic [15:0] O_WB_ALU  = 16'b0_0_0_0_0_0_0_00_00_1_0_0_00;
    localparam logic [15:0] O_WB_MDR  = 16'b0_0_0_0_0_0_0_00_00_1_1_0_00;
    localparam logic [15:0] O_FLT_ILL = 16'b0_0_0_0_0_0_0_00_00_0_0_1_01;
    localparam logic [15:0] O_FLT_TMO = 16'b0_0_0_0_0_0_0_00_00_0_0_1_10;

    assign all_out = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_src_a,
                      alu_src_b, alu_op, reg_write, wb_sel, fault, fault_code};

    multicycle_control_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .fault(fault), .fault_code(fault_code), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after a rising edge with the DUT in IDLE.
    task automatic apply_reset(input logic [15:0] instr);
        reset     = 1'b0;
        inst      = instr;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        inst      = 16'h0000;
        mem_ready = 1'b1;
        alu_zero  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        n_cmp++;
        if (all_out !== O_ZERO) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", all_out, O_ZERO);
        end
        $display("test_reset done");
    endtask

    task automatic test_rtype;
        logic [2:0]  st[6]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        logic [15:0] ex[6]  = '{O_ZERO, O_FETCH_R, O_DECODE, O_EXEC_R, O_WB_ALU, O_FETCH_R};
        apply_reset(16'h1230);
        for (int k = 0; k < 6; k++) begin
            mem_ready = 1'b1;
            #2;
            n_cmp++;
            if (state_dbg !== st[k]) begin
                n_err++;
                $display("FAIL rtype_state[%0d]: got %0d expected %0d", k, state_dbg, st[k]);
            end
            n_cmp++;
            if (all_out !== ex[k]) begin
                n_err++;
                $display("FAIL rtype_out[%0d]: got %b expected %b", k, all_out, ex[k]);
            end
            @(posedge clk);
            #1;
        end
        $display("test_rtype done");
    endtask

    task automatic test_lui;
        logic [2:0]  st[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        logic [15:0] ex[6] = '{O_ZERO, O_FETCH_R, O_DECODE, O_EXEC_U, O_WB_ALU, O_FETCH_R};
        apply_reset(16'h0005);
        for (int k = 0; k < 6; k++) begin
            mem_ready = 1'b1;
            #2;
            n_cmp++;
            if (state_dbg !== st[k] || all_out !== ex[k]) begin
                n_err++;
                $display("FAIL lui[%0d]: got state %0d out %b expected state %0d out %b",
                         k, state_dbg, all_out, st[k], ex[k]);
            end
            @(posedge clk);
            #1;
        end
        $display("test_lui done");
    endtask

    task automatic test_lw_wait;
        logic        mr[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0]  st[13] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3,
                                3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
        logic [15:0] ex[13] = '{O_ZERO, O_FETCH_W, O_FETCH_W, O_FETCH_W, O_FETCH_R, O_DECODE,
                                O_EXEC_I, O_MEM_LW, O_MEM_LW, O_MEM_LW, O_MEM_LW, O_WB_MDR,
                                O_FETCH_R};
        apply_reset(16'h0059);
        for (int k = 0; k < 13; k++) begin
            mem_ready = mr[k];
            #2;
            n_cmp++;
            if (state_dbg !== st[k] || all_out !== ex[k]) begin
                n_err++;
                $display("FAIL lw_wait[%0d]: got state %0d out %b expected state %0d out %b",
                         k, state_dbg, all_out, st[k], ex[k]);
            end
            @(posedge clk);
            #1;
        end
        $display("test_lw_wait done");
    endtask

    task automatic test_beq;
        logic [2:0]  st[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1};
        logic [15:0] ex_exec;
        for (int run = 0; run < 2; run++) begin
            apply_reset(16'h0806);
            ex_exec = (run == 0) ? 16'b1_0_0_0_0_0_1_00_01_0_0_0_00
                                 : 16'b0_0_0_0_0_0_1_00_01_0_0_0_00;
            for (int k = 0; k < 5; k++) begin
                mem_ready = 1'b1;
                alu_zero  = (run == 0);
                #2;
                n_cmp++;
                if (state_dbg !== st[k]) begin
                    n_err++;
                    $display("FAIL beq_state[run%0d,%0d]: got %0d expected %0d",
                             run, k, state_dbg, st[k]);
                end
                if (k == 3) begin
                    n_cmp++;
                    if ((all_out & 16'hBFFF) !== ex_exec) begin
                        n_err++;
                        $display("FAIL beq_exec[run%0d]: got %b expected %b (pc_src ignored)",
                                 run, all_out & 16'hBFFF, ex_exec);
                    end
                    if (run == 0) begin
                        n_cmp++;
                        if (pc_src !== 1'b1) begin
                            n_err++;
                            $display("FAIL beq_pc_src: got %b expected 1", pc_src);
                        end
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        $display("test_beq done");
    endtask

    task automatic test_illegal;
        apply_reset(16'h0003);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            #1;
            n_cmp++;
            if (state_dbg !== 3'd7 || all_out !== O_FLT_ILL) begin
                n_err++;
                $display("FAIL illegal_fault[%0d]: got state %0d out %b expected state 7 out %b",
                         k, state_dbg, all_out, O_FLT_ILL);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state_dbg !== 3'd0 || all_out !== O_ZERO) begin
            n_err++;
            $display("FAIL illegal_reset: got state %0d out %b expected state 0 out %b",
                     state_dbg, all_out, O_ZERO);
        end
        $display("test_illegal done");
    endtask

    task automatic test_timeout;
        // Run 0 never sees ready; run 1 sees it on the 16th FETCH cycle.
        for (int run = 0; run < 2; run++) begin
            apply_reset(16'h1230);
            @(posedge clk);
            #1;
            for (int k = 1; k <= 16; k++) begin
                mem_ready = (run == 1 && k == 16);
                #1;
                n_cmp++;
                if (state_dbg !== 3'd1) begin
                    n_err++;
                    $display("FAIL timeout_fetch[run%0d,%0d]: got state %0d expected 1",
                             run, k, state_dbg);
                end
                @(posedge clk);
                #1;
            end
            mem_ready = 1'b0;
            #1;
            n_cmp++;
            if (run == 0 && (state_dbg !== 3'd7 || all_out !== O_FLT_TMO)) begin
                n_err++;
                $display("FAIL timeout_fault: got state %0d out %b expected state 7 out %b",
                         state_dbg, all_out, O_FLT_TMO);
            end else if (run == 1 && (state_dbg !== 3'd2 || fault !== 1'b0)) begin
                n_err++;
                $display("FAIL timeout_ready_wins: got state %0d fault %b expected state 2 fault 0",
                         state_dbg, fault);
            end
        end
        $display("test_timeout done");
    endtask

    task automatic test_sw;
        logic        mr[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  st[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1};
        logic [15:0] ex[7] = '{O_ZERO, O_FETCH_R, O_DECODE, O_EXEC_I, O_MEM_SW, O_MEM_SW,
                               O_FETCH_R};
        apply_reset(16'h005A);
        for (int k = 0; k < 7; k++) begin
            mem_ready = mr[k];
            #2;
            n_cmp++;
            if (state_dbg !== st[k] || all_out !== ex[k]) begin
                n_err++;
                $display("FAIL sw[%0d]: got state %0d out %b expected state %0d out %b",
                         k, state_dbg, all_out, st[k], ex[k]);
            end
            @(posedge clk);
            #1;
        end
        // Reset in the middle of a stalled store.
        apply_reset(16'h005A);
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (state_dbg !== 3'd4 || mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL sw_mem_wait: got state %0d mem_write %b expected state 4 mem_write 1",
                     state_dbg, mem_write);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state_dbg !== 3'd0 || mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL sw_async_reset: got state %0d mem_write %b expected state 0 mem_write 0",
                     state_dbg, mem_write);
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_dbg !== 3'd1) begin
            n_err++;
            $display("FAIL sw_after_reset: got state %0d expected 1", state_dbg);
        end
        $display("test_sw done");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lui();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_sw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences the 16-bit multicycle datapath: fetch, decode, execute, memory, write-back.
- Decodes the opcode field inst[3:0] using the same opcode classes the immediate generator recognises.
- Drives PC/IR write enables, ALU source and operation selects, memory strobes and register write-back.
- Stalls on a variable-latency memory handshake and enters a sticky fault state on an illegal opcode or a memory timeout.

Parameters:
- TIMEOUT_CYCLES, 15: maximum consecutive cycles mem_ready may stay low in FETCH or MEM before a fault; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  16  current IR contents; opcode = inst[3:0].
- mem_ready  in  1  memory completes the current read or write this cycle.
- alu_zero  in  1  ALU result == 0.
- pc_write  out  1  load PC.
- pc_src  out  1  0 = ALU result (PC+2), 1 = ALUOut register.
- ir_write  out  1  load IR from memory data.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = register B, 1 = constant 2, 2 = immediate-generator output, 3 = reserved (never driven).
- alu_op  out  2  00 = ADD, 01 = SUB, 10 = funct from inst[15:12], 11 = PASS_B.
- reg_write  out  1  register-file write enable.
- wb_sel  out  1  0 = ALUOut, 1 = MDR.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- state_dbg  out  3  current state encoding.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Value 6 is unused and recovers to IDLE.
- Reset (reset low, asynchronous):
  - state=IDLE, fault=0, fault_code=00, wait counter=0.
  - All outputs 0 while reset is asserted.
- Output decoding:
  - Outputs are decoded from the state register. Only pc_write and ir_write may also depend on mem_ready or alu_zero.
  - Any output not listed for a state is 0.
- IDLE: no strobes; next state FETCH unconditionally.
- FETCH:
  - Drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00.
  - When mem_ready=1: ir_write=1 and pc_write=1 with pc_src=0 (PC+2) in that same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=2, alu_op=00, so ALUOut captures the branch target. Next state by opcode:
  - 0000, 0101, 0110, 1000, 1001, 1010, 1111 → EXEC.
  - Any other opcode → FAULT with code 01.
- EXEC, by opcode class:
  - 0000 (R-type): a=1, b=0, op=10; next WB.
  - 1000 (ADDI), 1001 (LW), 1010 (SW): a=1, b=2, op=00; ADDI next WB, LW/SW next MEM.
  - 0101 (LUI), 1111 (LI): b=2, op=11; next WB.
  - 0110 (BEQ): a=1, b=0, op=01. If alu_zero=1 then pc_write=1 and pc_src=1 in this cycle. Next FETCH.
- MEM:
  - iord=1.
  - LW: mem_read=1; SW: mem_write=1.
  - Strobes are held until mem_ready=1. Then LW goes to WB and SW goes to FETCH.
- WB: reg_write=1 for exactly one cycle; wb_sel=1 for LW, else 0; next FETCH.
- Wait counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle in FETCH or MEM with mem_ready=0, saturating at TIMEOUT_CYCLES.
  - If the counter equals TIMEOUT_CYCLES and mem_ready=0, next state is FAULT with code 10.
  - If mem_ready=1 in that same cycle, the ready path wins and no fault is raised.
- FAULT:
  - All strobes 0 and fault=1.
  - fault_code holds the first cause recorded.
  - The FSM stays in FAULT until reset is asserted.
- Reset asserted mid-transaction (for example during a MEM wait) clears everything immediately, with no completion of the pending access.
- Each instruction asserts pc_write at most once per state visit and reg_write at most once.
- Latency in cycles, assuming mem_ready is already high:
  - R, ADDI, LUI, LI: 4 (FETCH, DECODE, EXEC, WB).
  - BEQ: 3.
  - SW: 4.
  - LW: 5.

Test Plan:
- Reset release with mem_ready=1 and inst=0x1230 (R-type) → state_dbg sequence 0,1,2,3,5,1. ir_write and pc_write high in FETCH. alu_op=10 in EXEC. reg_write=1 only in WB.
- inst=0x0059 (LW), mem_ready low for 3 cycles in both FETCH and MEM → mem_read held 4 cycles in each state. iord=1 in MEM. WB has wb_sel=1. No fault.
- inst=0x0806 (BEQ): run once with alu_zero=1 and once with alu_zero=0 → pc_write=1 with pc_src=1 in EXEC only when alu_zero=1. Both runs return to FETCH after 3 cycles.
- inst=0x0003 (illegal opcode) → after DECODE, state_dbg=7, fault=1, fault_code=01. FSM stays there for 20 cycles. Asserting reset low returns state_dbg to 0.
- TIMEOUT_CYCLES=15 with mem_ready stuck low in FETCH → FAULT, fault_code=10, on the 16th FETCH cycle. A second run raises mem_ready exactly on that 16th cycle → DECODE, no fault.
- Assert reset low during the MEM wait of SW (inst=0x005A) → mem_write drops asynchronously to 0 and state_dbg goes to 0. After release, the next state is FETCH.
